// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data single-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_ERROR    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    BSEL_WORD = 2'b00,
    BSEL_HALF = 2'b01,
    BSEL_BYTE = 2'b10
  } bsel_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-stage and unified-memory signals of the arbiter, grouped as one bus.
interface mem_port_arbiter_if;
  logic        IF_Req;
  logic [31:0] IF_Addr;
  logic        IF_Grant;
  logic [31:0] IF_RData;
  logic        IF_Stall;

  logic        MEM_Req;
  logic        MEM_Write;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_WData;
  logic [1:0]  MEM_ByteSel;
  logic        MEM_Grant;
  logic [31:0] MEM_RData;
  logic        MEM_Stall;

  logic        Mem_Req;
  logic        Mem_Write;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [1:0]  Mem_ByteSel;
  logic        Mem_Ready;
  logic [31:0] Mem_RData;

  logic        Err;

  modport slave (
    input  IF_Req, IF_Addr,
    output IF_Grant, IF_RData, IF_Stall,
    input  MEM_Req, MEM_Write, MEM_Addr, MEM_WData, MEM_ByteSel,
    output MEM_Grant, MEM_RData, MEM_Stall,
    output Mem_Req, Mem_Write, Mem_Addr, Mem_WData, Mem_ByteSel,
    input  Mem_Ready, Mem_RData,
    output Err
  );

  modport master (
    output IF_Req, IF_Addr,
    input  IF_Grant, IF_RData, IF_Stall,
    output MEM_Req, MEM_Write, MEM_Addr, MEM_WData, MEM_ByteSel,
    input  MEM_Grant, MEM_RData, MEM_Stall,
    input  Mem_Req, Mem_Write, Mem_Addr, Mem_WData, Mem_ByteSel,
    output Mem_Ready, Mem_RData,
    input  Err
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait counter; expired flags the cycle the count reaches MAX_WAIT.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count_q, count_d;

  // expired looks at the next count so the owner can leave BUSY on the same edge
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CW'(MAX_WAIT))) begin
      count_d = count_q + CW'(1);
    end
    expired = (count_d == CW'(MAX_WAIT));
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage accesses onto one registered single-port memory command.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                Clock,
  input  logic                Reset,
  mem_port_arbiter_if.slave   bus
);
  import mem_port_arbiter_pkg::*;

  arb_state_e  state_q, state_d;
  owner_e      last_owner_q, last_owner_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_bsel_q, mem_bsel_d;
  logic        if_grant_q, if_grant_d;
  logic        mem_grant_q, mem_grant_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        err_q, err_d;

  logic if_elig, mem_elig, pick_mem, busy;
  logic timer_clear, timer_enable, timer_expired;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (Clock),
    .rst     (Reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_bsel_d   = mem_bsel_q;
    if_grant_d   = 1'b0;
    mem_grant_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    err_d        = err_q;
    timer_clear  = 1'b0;

    // a requester still showing Req during its grant cycle is describing the finished access
    if_elig  = bus.IF_Req  & ~if_grant_q;
    mem_elig = bus.MEM_Req & ~mem_grant_q;
    pick_mem = mem_elig & (~if_elig | (last_owner_q == OWNER_IF));
    busy     = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);
    timer_enable = busy & ~bus.Mem_Ready;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_mem) begin
          state_d     = ST_BUSY_MEM;
          mem_req_d   = 1'b1;
          mem_write_d = bus.MEM_Write;
          mem_addr_d  = bus.MEM_Addr;
          mem_wdata_d = bus.MEM_WData;
          mem_bsel_d  = bus.MEM_ByteSel;
          timer_clear = 1'b1;
        end else if (if_elig) begin
          state_d     = ST_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = bus.IF_Addr;
          mem_wdata_d = '0;
          mem_bsel_d  = BSEL_WORD;
          timer_clear = 1'b1;
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (bus.Mem_Ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (state_q == ST_BUSY_IF) begin
            if_grant_d   = 1'b1;
            if_rdata_d   = bus.Mem_RData;
            last_owner_d = OWNER_IF;
          end else begin
            mem_grant_d  = 1'b1;
            if (!mem_write_q) mem_rdata_d = bus.Mem_RData;
            last_owner_d = OWNER_MEM;
          end
        end else if (timer_expired) begin
          state_d   = ST_ERROR;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_IF;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_bsel_q   <= BSEL_WORD;
      if_grant_q   <= 1'b0;
      mem_grant_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_bsel_q   <= mem_bsel_d;
      if_grant_q   <= if_grant_d;
      mem_grant_q  <= mem_grant_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    bus.Mem_Req     = mem_req_q;
    bus.Mem_Write   = mem_write_q;
    bus.Mem_Addr    = mem_addr_q;
    bus.Mem_WData   = mem_wdata_q;
    bus.Mem_ByteSel = mem_bsel_q;
    bus.IF_Grant    = if_grant_q;
    bus.IF_RData    = if_rdata_q;
    bus.MEM_Grant   = mem_grant_q;
    bus.MEM_RData   = mem_rdata_q;
    bus.Err         = err_q;
    bus.IF_Stall    = (state_q == ST_ERROR) | (bus.IF_Req  & ~if_grant_q);
    bus.MEM_Stall   = (state_q == ST_ERROR) | (bus.MEM_Req & ~mem_grant_q);
  end
endmodule
